// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage ahead of the decoder.
// Owns the PC and fetches one 32-bit word at a time from instruction memory
// over a req/ack handshake. Each word is presented with its PC to the decoder
// over valid/ready. Absolute redirects from downstream restart fetching at a
// new target; an in-flight request made stale by a redirect is drained and
// its response discarded.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   imem_req     fetch request, held until imem_ack
//   imem_addr    word address of the request (stable while imem_req high)
//   imem_ack     response strobe, imem_rdata valid in the same cycle
//   imem_rdata   fetched instruction word
//   instr        instruction presented to the decoder
//   instr_pc     PC of instr
//   instr_valid  instr/instr_pc valid
//   instr_ready  decoder consumes instr when instr_valid & instr_ready
//   redirect     one-cycle request to continue fetching at redirect_pc
//   redirect_pc  redirect target (bits [1:0] are dropped)
//   fetch_fault  one-cycle pulse after a redirect with a misaligned target
//   instr_count  number of instructions consumed by the decoder
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] instr_count
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INSTR_BYT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pending_pc;
  logic [XLEN-1:0] target_c;
  logic            consume_c;

  // Redirect target with the byte offset stripped
  assign target_c  = {redirect_pc[XLEN-1:2], 2'b00};

  // Decoder handshake completes this cycle
  assign consume_c = (state == VALID) && instr_ready;

  // Outputs decode from registers only; no input-to-output paths
  assign imem_req    = (state == REQ) || (state == DRAIN);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);

  // Fetch FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pending_pc  <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_fault <= 1'b0;
    end else begin
      // Misalignment is reported but the aligned redirect still proceeds
      fetch_fault <= redirect && (redirect_pc[1:0] != 2'b00);

      unique case (state)
        IDLE: begin
          if (redirect) begin
            pc <= target_c;
          end
          state <= REQ;
        end

        REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              // Response is already stale; restart at the target next cycle
              pc <= target_c;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc;
              state    <= VALID;
            end
          end else if (redirect) begin
            // Address must stay put until the memory acks the old request
            pending_pc <= target_c;
            state      <= DRAIN;
          end
        end

        DRAIN: begin
          if (imem_ack) begin
            // A redirect arriving with the ack is newer than pending_pc
            pc    <= redirect ? target_c : pending_pc;
            state <= REQ;
          end else if (redirect) begin
            pending_pc <= target_c;
          end
        end

        VALID: begin
          if (redirect) begin
            pc    <= target_c;
            state <= REQ;
          end else if (instr_ready) begin
            pc    <= XLEN'(instr_pc + XLEN'(INSTR_BYT));
            state <= REQ;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Consumed-instruction counter; a word consumed alongside a redirect counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (consume_c) begin
      instr_count <= XLEN'(instr_count + XLEN'(1));
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch with zero-wait memory,
// decoder stall, redirects in VALID/REQ/DRAIN, misaligned redirect, PC wrap
// and asynchronous reset mid-request.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] SALT   = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] instr_count;

  // Memory model: zero-wait mode acks every request in its first cycle,
  // otherwise the ack is driven by hand. Data depends on the address.
  logic zw;
  logic ack_man;
  assign imem_ack   = zw ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ SALT;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault),
    .instr_count(instr_count)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ SALT;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    zw          = 1'b1;
    ack_man     = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    tick();
    tick();

    // Reset values
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  imem_addr,        RST_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_count", instr_count,      32'd0);
    chk("rst_instr", instr,            32'd0);
    chk("rst_ipc",   instr_pc,         32'd0);

    // Cycle 0 after release is IDLE
    reset = 1'b1;
    chk("c0_req", 32'(imem_req), 32'd0);
    tick();
    chk("c1_req",   32'(imem_req),    32'd1);
    chk("c1_addr",  imem_addr,        RST_PC);
    chk("c1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("c2_valid", 32'(instr_valid), 32'd1);
    chk("c2_ipc",   instr_pc,         RST_PC);
    chk("c2_instr", instr,            word_at(RST_PC));
    chk("c2_req",   32'(imem_req),    32'd0);

    // Sequential stream: one instruction every two cycles
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("seq_req",   32'(imem_req),    32'd1);
      chk("seq_addr",  imem_addr,        RST_PC + 32'(4 * k));
      chk("seq_valid", 32'(instr_valid), 32'd0);
      chk("seq_count", instr_count,      32'(k));
      tick();
      chk("seq_vld",   32'(instr_valid), 32'd1);
      chk("seq_ipc",   instr_pc,         RST_PC + 32'(4 * k));
      chk("seq_instr", instr,            word_at(RST_PC + 32'(4 * k)));
    end

    // Decoder stall: word held, no request, pc frozen
    instr_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_ipc",   instr_pc,         RST_PC + 32'h0C);
      chk("stall_instr", instr,            word_at(RST_PC + 32'h0C));
      chk("stall_req",   32'(imem_req),    32'd0);
      chk("stall_addr",  imem_addr,        RST_PC + 32'h0C);
      chk("stall_count", instr_count,      32'd3);
    end
    instr_ready = 1'b1;
    tick();
    chk("unstall_addr",  imem_addr,     RST_PC + 32'h10);
    chk("unstall_req",   32'(imem_req), 32'd1);
    chk("unstall_count", instr_count,   32'd4);

    // Redirect coincident with ack in REQ: restart at the target
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0010;
    tick();
    chk("rq_redir_addr",  imem_addr,        32'h0000_0010);
    chk("rq_redir_req",   32'(imem_req),    32'd1);
    chk("rq_redir_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b0;
    tick();
    chk("hold10_valid", 32'(instr_valid), 32'd1);
    chk("hold10_ipc",   instr_pc,         32'h0000_0010);
    chk("hold10_instr", instr,            word_at(32'h0000_0010));

    // Redirect in VALID without ready: word dropped, not counted
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    chk("rv_addr",  imem_addr,        32'h0000_0080);
    chk("rv_req",   32'(imem_req),    32'd1);
    chk("rv_valid", 32'(instr_valid), 32'd0);
    chk("rv_count", instr_count,      32'd4);
    redirect = 1'b0;
    tick();
    chk("hold80_ipc",   instr_pc,    32'h0000_0080);
    chk("hold80_count", instr_count, 32'd4);

    // Redirect in VALID with ready: word still counts as consumed
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0020;
    zw          = 1'b0;
    ack_man     = 1'b0;
    tick();
    chk("rvr_addr",  imem_addr,        32'h0000_0020);
    chk("rvr_valid", 32'(instr_valid), 32'd0);
    chk("rvr_count", instr_count,      32'd5);

    // Two redirects during a 3-wait-state fetch at 0x20
    instr_ready = 1'b0;
    redirect_pc = 32'h0000_0060;
    tick();
    chk("dr1_addr", imem_addr,     32'h0000_0020);
    chk("dr1_req",  32'(imem_req), 32'd1);
    redirect_pc = 32'h0000_0100;
    tick();
    chk("dr2_addr", imem_addr,     32'h0000_0020);
    chk("dr2_req",  32'(imem_req), 32'd1);
    redirect = 1'b0;
    tick();
    chk("dr3_addr",  imem_addr,        32'h0000_0020);
    chk("dr3_valid", 32'(instr_valid), 32'd0);
    ack_man = 1'b1;
    tick();
    chk("dr_ack_addr",  imem_addr,        32'h0000_0100);
    chk("dr_ack_req",   32'(imem_req),    32'd1);
    chk("dr_ack_valid", 32'(instr_valid), 32'd0);
    chk("dr_ack_count", instr_count,      32'd5);
    ack_man = 1'b0;
    tick();
    chk("w100_addr",  imem_addr,        32'h0000_0100);
    chk("w100_valid", 32'(instr_valid), 32'd0);
    ack_man = 1'b1;
    tick();
    chk("v100_valid", 32'(instr_valid), 32'd1);
    chk("v100_ipc",   instr_pc,         32'h0000_0100);
    chk("v100_instr", instr,            word_at(32'h0000_0100));
    ack_man     = 1'b0;
    instr_ready = 1'b1;
    tick();
    chk("c100_addr",  imem_addr,   32'h0000_0104);
    chk("c100_count", instr_count, 32'd6);

    // Misaligned redirect while a request is outstanding
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0046;
    tick();
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_addr",  imem_addr,        32'h0000_0104);
    redirect = 1'b0;
    tick();
    chk("mis_fault_clr", 32'(fetch_fault), 32'd0);
    ack_man = 1'b1;
    tick();
    chk("mis_next_addr", imem_addr,     32'h0000_0044);
    chk("mis_next_req",  32'(imem_req), 32'd1);

    // PC wrap at the top of the address space
    ack_man     = 1'b0;
    zw          = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    zw          = 1'b0;
    instr_ready = 1'b1;
    tick();
    chk("wrap_addr",  imem_addr,        32'h0000_0000);
    chk("wrap_req",   32'(imem_req),    32'd1);
    chk("wrap_fault", 32'(fetch_fault), 32'd0);
    chk("wrap_count", instr_count,      32'd7);

    // Asynchronous reset in the middle of an outstanding request
    #2;
    reset = 1'b0;
    #1;
    chk("areset_req",   32'(imem_req),    32'd0);
    chk("areset_valid", 32'(instr_valid), 32'd0);
    chk("areset_addr",  imem_addr,        RST_PC);
    chk("areset_count", instr_count,      32'd0);
    tick();
    tick();
    reset = 1'b1;
    chk("rel_c0_req", 32'(imem_req), 32'd0);
    tick();
    chk("rel_c1_req",  32'(imem_req), 32'd1);
    chk("rel_c1_addr", imem_addr,     RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
